// File: rtl/sal_bk_pkg.sv
// Shared types for the per-bank controller: command codes, bank state,
// the one-entry pending request and the timing-counter geometry.
package sal_bk_pkg;

  // Request geometry. The controller's width parameters default to these and
  // must match them, because the pending-request struct is built from them.
  localparam int unsigned SAL_ROW_W = 16;
  localparam int unsigned SAL_COL_W = 10;
  localparam int unsigned SAL_ID_W  = 4;

  // Wide enough for any realistic DRAM timing constraint in controller cycles.
  localparam int unsigned TCNT_W = 8;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } cmd_t;

  typedef enum logic {
    BK_CLOSED = 1'b0,
    BK_OPEN   = 1'b1
  } bk_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [SAL_ROW_W-1:0] row;
    logic [SAL_COL_W-1:0] col;
    logic [SAL_ID_W-1:0]  id;
  } pend_t;

  // Reload value for an n-cycle constraint: n-1 at the grant edge means the
  // constraint reads as met exactly n cycles after the granted command.
  function automatic logic [TCNT_W-1:0] tcnt_load(input int unsigned n);
    return TCNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/sal_tcnt.sv
// Saturating down-counter for one bank timing constraint. Zero means the
// constraint is satisfied; a load takes priority over counting.
module sal_tcnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload on grant, otherwise step toward zero and stick there.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, cleared to "constraint met" by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sal_bk_ctrl.sv
// Per-bank controller: holds one decoded request, tracks the open row and the
// bank timing constraints, and offers a single candidate command to the
// scheduler under a valid/grant handshake. Open-page policy.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   BK_CLOSED | no row open; ACT offered once a request waits and tRP is met
//   BK_OPEN   | open_row_q active; RD/WR on a hit, PRE on a miss or refresh
module sal_bk_ctrl
  import sal_bk_pkg::*;
#(
  parameter int unsigned ROW_W = SAL_ROW_W,
  parameter int unsigned COL_W = SAL_COL_W,
  parameter int unsigned ID_W  = SAL_ID_W,
  parameter int unsigned TRCD  = 3,
  parameter int unsigned TRP   = 3,
  parameter int unsigned TRAS  = 8,
  parameter int unsigned TRTP  = 2,
  parameter int unsigned TWR   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic [ID_W-1:0]  req_id,
  output logic             cmd_valid,
  output logic [1:0]       cmd_type,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  output logic [ID_W-1:0]  cmd_id,
  input  logic             cmd_grant,
  input  logic             ref_req,
  output logic             ref_ack
);

  bk_state_t        state_q, state_d;
  logic [ROW_W-1:0] open_row_q, open_row_d;
  pend_t            pend_q, pend_d;
  // Registered refresh demand keeps the command outputs a function of flops.
  logic             ref_q;

  logic rcd_ok, rp_ok, ras_ok, rtp_ok, wr_ok;
  logic row_hit, pre_ok;
  logic cand_valid;
  cmd_t cand_type;
  logic out_en, granted;
  logic ld_act, ld_rd, ld_wr, ld_pre;

  // Candidate selection from registered state and timer zero flags only.
  always_comb begin
    cand_valid = 1'b0;
    cand_type  = CMD_ACT;
    row_hit    = pend_q.valid && (pend_q.row == open_row_q);
    pre_ok     = ras_ok && rtp_ok && wr_ok;
    if (state_q == BK_CLOSED) begin
      if (pend_q.valid && rp_ok) begin
        cand_valid = 1'b1;
        cand_type  = CMD_ACT;
      end
    end else if (row_hit) begin
      // A hit waits for tRCD rather than closing the row.
      if (rcd_ok) begin
        cand_valid = 1'b1;
        cand_type  = pend_q.wr ? CMD_WR : CMD_RD;
      end
    end else if ((pend_q.valid || ref_q) && pre_ok) begin
      // Reached only on a miss or, with nothing pending, on refresh demand,
      // so a pending request always completes before a refresh close.
      cand_valid = 1'b1;
      cand_type  = CMD_PRE;
    end
  end

  assign out_en    = cand_valid && !rst;
  assign cmd_valid = out_en;
  assign cmd_type  = out_en ? cand_type : CMD_ACT;
  assign cmd_row   = (out_en && cand_type == CMD_ACT) ? pend_q.row : '0;
  assign cmd_col   = (out_en && (cand_type == CMD_RD || cand_type == CMD_WR)) ? pend_q.col : '0;
  assign cmd_id    = (out_en && (cand_type == CMD_RD || cand_type == CMD_WR)) ? pend_q.id : '0;

  assign req_ready = !rst && !pend_q.valid && !ref_req;
  assign ref_ack   = !rst && ref_req && (state_q == BK_CLOSED) && !pend_q.valid && rp_ok;

  assign granted = cand_valid && cmd_grant;
  assign ld_act  = granted && (cand_type == CMD_ACT);
  assign ld_rd   = granted && (cand_type == CMD_RD);
  assign ld_wr   = granted && (cand_type == CMD_WR);
  assign ld_pre  = granted && (cand_type == CMD_PRE);

  // Next state: apply the granted command, then capture an accepted request.
  always_comb begin
    state_d    = state_q;
    open_row_d = open_row_q;
    pend_d     = pend_q;
    if (ld_act) begin
      state_d    = BK_OPEN;
      open_row_d = pend_q.row;
    end
    if (ld_rd || ld_wr) begin
      pend_d.valid = 1'b0;
    end
    if (ld_pre) begin
      state_d = BK_CLOSED;
    end
    // req_ready already excludes an occupied slot, so no same-cycle refill.
    if (req_valid && req_ready) begin
      pend_d.valid = 1'b1;
      pend_d.wr    = req_wr;
      pend_d.row   = req_row;
      pend_d.col   = req_col;
      pend_d.id    = req_id;
    end
  end

  // State registers; reset drops any pending request and closes the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BK_CLOSED;
      open_row_q <= '0;
      pend_q     <= '0;
      ref_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      open_row_q <= open_row_d;
      pend_q     <= pend_d;
      ref_q      <= ref_req;
    end
  end

  sal_tcnt #(.W(TCNT_W)) u_trcd (
    .clk(clk), .rst(rst), .load_i(ld_act), .load_val_i(tcnt_load(TRCD)), .zero_o(rcd_ok)
  );
  sal_tcnt #(.W(TCNT_W)) u_tras (
    .clk(clk), .rst(rst), .load_i(ld_act), .load_val_i(tcnt_load(TRAS)), .zero_o(ras_ok)
  );
  sal_tcnt #(.W(TCNT_W)) u_trtp (
    .clk(clk), .rst(rst), .load_i(ld_rd), .load_val_i(tcnt_load(TRTP)), .zero_o(rtp_ok)
  );
  sal_tcnt #(.W(TCNT_W)) u_twr (
    .clk(clk), .rst(rst), .load_i(ld_wr), .load_val_i(tcnt_load(TWR)), .zero_o(wr_ok)
  );
  sal_tcnt #(.W(TCNT_W)) u_trp (
    .clk(clk), .rst(rst), .load_i(ld_pre), .load_val_i(tcnt_load(TRP)), .zero_o(rp_ok)
  );

  // A grant with nothing offered points at a scheduler bug; it is ignored.
  a_grant_needs_valid: assert property (@(posedge clk) disable iff (rst) cmd_grant |-> cmd_valid);

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// Bench for sal_bk_ctrl: directed scenarios plus a randomized run, all checked
// against a cycle-stamp reference model (constraint met when enough cycles
// have elapsed since the last relevant granted command).
module tb_sal_bk_ctrl;

  localparam int TRCD = 3, TRP = 3, TRAS = 8, TRTP = 2, TWR = 5;
  localparam logic [1:0] T_ACT = 2'd0, T_RD = 2'd1, T_WR = 2'd2, T_PRE = 2'd3;
  localparam int NEVER = -1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wr = 1'b0;
  logic [15:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic [3:0]  req_id = '0;
  logic        cmd_valid;
  logic [1:0]  cmd_type;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [3:0]  cmd_id;
  logic        cmd_grant;
  logic        ref_req = 1'b0, ref_ack;
  logic        g_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // The scheduler only grants what is offered.
  assign cmd_grant = g_en & cmd_valid;

  sal_bk_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_row(req_row), .req_col(req_col), .req_id(req_id),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .cmd_id(cmd_id), .cmd_grant(cmd_grant),
    .ref_req(ref_req), .ref_ack(ref_ack)
  );

  // Reference model state: bank status plus the cycle of the last grant of each kind.
  int          cyc = 0;
  logic        m_open = 1'b0, m_pv = 1'b0, m_pwr = 1'b0, m_refq = 1'b0;
  logic [15:0] m_row = '0, m_prow = '0;
  logic [9:0]  m_pcol = '0;
  logic [3:0]  m_pid = '0;
  int          t_act = NEVER, t_rd = NEVER, t_wr = NEVER, t_pre = NEVER;

  logic        e_valid, e_ready, e_ack;
  logic [1:0]  e_type;
  logic [15:0] e_row;
  logic [9:0]  e_col;
  logic [3:0]  e_id;

  always_comb begin
    e_valid = 1'b0; e_type = 2'd0; e_row = '0; e_col = '0; e_id = '0;
    e_ready = 1'b0; e_ack = 1'b0;
    if (!rst) begin
      e_ready = !m_pv && !ref_req;
      e_ack   = ref_req && !m_open && !m_pv && (cyc - t_pre >= TRP);
      if (!m_open) begin
        if (m_pv && (cyc - t_pre >= TRP)) begin
          e_valid = 1'b1; e_type = T_ACT; e_row = m_prow;
        end
      end else if (m_pv && m_prow == m_row) begin
        if (cyc - t_act >= TRCD) begin
          e_valid = 1'b1; e_type = m_pwr ? T_WR : T_RD; e_col = m_pcol; e_id = m_pid;
        end
      end else if ((m_pv || m_refq) && (cyc - t_act >= TRAS) &&
                   (cyc - t_rd >= TRTP) && (cyc - t_wr >= TWR)) begin
        e_valid = 1'b1; e_type = T_PRE;
      end
    end
  end

  always @(posedge clk) begin
    logic       g, acc;
    logic [1:0] ty;
    g   = e_valid && cmd_grant;
    ty  = e_type;
    acc = req_valid && e_ready;
    if (rst) begin
      m_open = 1'b0; m_pv = 1'b0; m_refq = 1'b0; m_row = '0;
      t_act = NEVER; t_rd = NEVER; t_wr = NEVER; t_pre = NEVER;
    end else begin
      if (g) begin
        case (ty)
          T_ACT:   begin m_open = 1'b1; m_row = m_prow; t_act = cyc; end
          T_RD:    begin m_pv = 1'b0; t_rd = cyc; end
          T_WR:    begin m_pv = 1'b0; t_wr = cyc; end
          default: begin m_open = 1'b0; t_pre = cyc; end
        endcase
      end
      if (acc) begin
        m_pv = 1'b1; m_pwr = req_wr; m_prow = req_row; m_pcol = req_col; m_pid = req_id;
      end
      m_refq = ref_req;
    end
    cyc++;
  end

  logic [34:0] dut_v, exp_v;
  assign dut_v = {req_ready, cmd_valid, cmd_type, cmd_row, cmd_col, cmd_id, ref_ack};
  assign exp_v = {e_ready, e_valid, e_type, e_row, e_col, e_id, e_ack};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic wr, input logic [15:0] row,
                           input logic [9:0] col, input logic [3:0] id);
    req_valid = v; req_wr = wr; req_row = row; req_col = col; req_id = id;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (dut_v !== 35'h0) begin
      errors++; $display("FAIL reset_outputs_during_rst got=%h want=%h", dut_v, 35'h0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_v !== {1'b1, 34'h0}) begin
      errors++; $display("FAIL reset_after_release got=%h want=%h", dut_v, {1'b1, 34'h0});
    end
    checks++;
    if (dut_v !== exp_v) begin
      errors++; $display("FAIL reset_model got=%h want=%h", dut_v, exp_v);
    end
  endtask

  task automatic test_basic_read();
    logic       ev;
    logic [1:0] et;
    logic [15:0] er;
    logic [9:0] ec;
    logic [3:0] ei;
    g_en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      case (k)
        0:       drive_req(1'b1, 1'b0, 16'h12, 10'h40, 4'd3);
        5:       drive_req(1'b1, 1'b0, 16'h12, 10'h44, 4'd5);
        7:       drive_req(1'b1, 1'b0, 16'h34, 10'h80, 4'd7);
        default: drive_req(1'b0, 1'b0, 16'h0, 10'h0, 4'd0);
      endcase
      ev = 1'b1; et = T_ACT; er = '0; ec = '0; ei = '0;
      case (k)
        1:       er = 16'h12;
        4:       begin et = T_RD; ec = 10'h40; ei = 4'd3; end
        6:       begin et = T_RD; ec = 10'h44; ei = 4'd5; end
        9:       et = T_PRE;
        12:      er = 16'h34;
        15:      begin et = T_RD; ec = 10'h80; ei = 4'd7; end
        default: ev = 1'b0;
      endcase
      @(negedge clk);
      checks++;
      if ({cmd_valid, cmd_type, cmd_row, cmd_col, cmd_id} !== {ev, et, er, ec, ei}) begin
        errors++;
        $display("FAIL basic_cmd cycle=%0d got=%b/%0d/%h/%h/%h want=%b/%0d/%h/%h/%h",
                 k, cmd_valid, cmd_type, cmd_row, cmd_col, cmd_id, ev, et, er, ec, ei);
      end
      if (k == 0 || k == 5 || k == 7) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++; $display("FAIL basic_req_ready cycle=%0d got=%b want=1", k, req_ready);
        end
      end
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL basic_model cycle=%0d got=%h want=%h", k, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_write_twr();
    int c_wr = -1;
    int c_pre = -1;
    g_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 0)      drive_req(1'b1, 1'b1, 16'h34, 10'h11, 4'd2);
      else if (k == 2) drive_req(1'b1, 1'b0, 16'h56, 10'h22, 4'd4);
      else             drive_req(1'b0, 1'b0, 16'h0, 10'h0, 4'd0);
      @(negedge clk);
      if (cmd_valid && cmd_type == T_WR && c_wr < 0) c_wr = k;
      if (cmd_valid && cmd_type == T_PRE && c_pre < 0) c_pre = k;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL write_model cycle=%0d got=%h want=%h", k, dut_v, exp_v);
      end
    end
    checks++;
    if (c_wr != 1) begin
      errors++; $display("FAIL write_hit_cycle got=%0d want=1", c_wr);
    end
    checks++;
    if (c_pre - c_wr != TWR) begin
      errors++; $display("FAIL write_to_pre_gap got=%0d want=%0d", c_pre - c_wr, TWR);
    end
  endtask

  task automatic test_refresh();
    int p = -1;
    g_en = 1'b1;
    drive_req(1'b0, 1'b0, 16'h0, 10'h0, 4'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      ref_req = 1'b1;
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL refresh_blocks_ready got=%b want=0", req_ready);
        end
      end
      if (cmd_valid && cmd_type == T_PRE && p < 0) p = k;
      if (p >= 0 && k == p + 2) begin
        checks++;
        if (ref_ack !== 1'b0) begin
          errors++; $display("FAIL refresh_ack_early got=%b want=0", ref_ack);
        end
      end
      if (p >= 0 && k == p + 3) begin
        checks++;
        if (ref_ack !== 1'b1) begin
          errors++; $display("FAIL refresh_ack_trp got=%b want=1", ref_ack);
        end
      end
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL refresh_model cycle=%0d got=%h want=%h", k, dut_v, exp_v);
      end
    end
    checks++;
    if (p < 0 || p > 16) begin
      errors++; $display("FAIL refresh_pre_seen got_cycle=%0d want=0..16", p);
    end
    tick();
    ref_req = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_v !== exp_v) begin
      errors++; $display("FAIL refresh_release_model got=%h want=%h", dut_v, exp_v);
    end
  endtask

  task automatic test_grant_hold();
    g_en = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k == 0) drive_req(1'b1, 1'b0, 16'h9A, 10'h3, 4'd9);
      else        drive_req(1'b0, 1'b0, 16'h0, 10'h0, 4'd0);
      if (k == 11) g_en = 1'b1;
      @(negedge clk);
      if (k >= 1 && k <= 11) begin
        checks++;
        if ({cmd_valid, cmd_type, cmd_row} !== {1'b1, T_ACT, 16'h9A}) begin
          errors++;
          $display("FAIL hold_act_stable cycle=%0d got=%b/%0d/%h want=1/0/9a",
                   k, cmd_valid, cmd_type, cmd_row);
        end
      end
      if (k == 12) begin
        checks++;
        if (cmd_valid !== 1'b0) begin
          errors++; $display("FAIL hold_act_issued got=%b want=0", cmd_valid);
        end
      end
      if (k == 14) begin
        checks++;
        if ({cmd_valid, cmd_type, cmd_col, cmd_id} !== {1'b1, T_RD, 10'h3, 4'd9}) begin
          errors++;
          $display("FAIL hold_rd_after_trcd got=%b/%0d/%h/%h want=1/1/3/9",
                   cmd_valid, cmd_type, cmd_col, cmd_id);
        end
      end
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL hold_model cycle=%0d got=%h want=%h", k, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    g_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      rst = (k == 0 || k == 3);
      if (k == 1)      drive_req(1'b1, 1'b0, 16'h21, 10'h5, 4'd1);
      else if (k == 4) drive_req(1'b1, 1'b0, 16'h21, 10'h6, 4'd2);
      else             drive_req(1'b0, 1'b0, 16'h0, 10'h0, 4'd0);
      @(negedge clk);
      if (k == 2) begin
        checks++;
        if ({cmd_valid, cmd_type, cmd_row} !== {1'b1, T_ACT, 16'h21}) begin
          errors++; $display("FAIL midrst_act got=%b/%0d/%h want=1/0/21", cmd_valid, cmd_type, cmd_row);
        end
      end
      if (k == 3) begin
        checks++;
        if (dut_v !== 35'h0) begin
          errors++; $display("FAIL midrst_outputs_zero got=%h want=0", dut_v);
        end
      end
      if (k == 4) begin
        checks++;
        if (dut_v !== {1'b1, 34'h0}) begin
          errors++; $display("FAIL midrst_release got=%h want=%h", dut_v, {1'b1, 34'h0});
        end
      end
      if (k == 5) begin
        checks++;
        if ({cmd_valid, cmd_type, cmd_row} !== {1'b1, T_ACT, 16'h21}) begin
          errors++;
          $display("FAIL midrst_bank_closed got=%b/%0d/%h want=1/0/21", cmd_valid, cmd_type, cmd_row);
        end
      end
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL midrst_model cycle=%0d got=%h want=%h", k, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst  = ($urandom_range(0, 599) == 0);
      g_en = ($urandom_range(0, 3) != 0);
      if (!ref_req)   ref_req = ($urandom_range(0, 79) == 0);
      else if (e_ack) ref_req = 1'b0;
      drive_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 2)), 10'($urandom), 4'($urandom));
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL random_model cycle=%0d got=%h want=%h", k, dut_v, exp_v);
      end
    end
    tick();
    rst = 1'b0; ref_req = 1'b0; g_en = 1'b0;
    drive_req(1'b0, 1'b0, 16'h0, 10'h0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write_twr();
    test_refresh();
    test_grant_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
